// File: rtl/pc_sequencer_if.sv
// Bundle of next-PC controller signals between hazard/branch logic and the PC register.
interface pc_sequencer_if #(
  parameter int unsigned bPC = 7
);
  logic [bPC-1:0] pc_current;
  logic           stall;
  logic           br_taken;
  logic [bPC-1:0] br_target;
  logic           jump;
  logic [bPC-1:0] jump_target;
  logic           halt;
  logic           resume;
  logic [bPC-1:0] pc_next;
  logic           flush_if;
  logic           flush_id;
  logic           fetch_valid;
  logic [1:0]     state;
  logic           stall_err;

  // Pipeline side: presents PC, hazards and redirects; consumes next PC and flushes.
  modport master (
    output pc_current, stall, br_taken, br_target, jump, jump_target, halt, resume,
    input  pc_next, flush_if, flush_id, fetch_valid, state, stall_err
  );

  // Sequencer side.
  modport slave (
    input  pc_current, stall, br_taken, br_target, jump, jump_target, halt, resume,
    output pc_next, flush_if, flush_id, fetch_valid, state, stall_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential increment, branch/jump
// redirect, stall hold, halt/resume, flush strobes and a stall watchdog.
module pc_sequencer #(
  parameter int unsigned bPC       = 7,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned WDOG      = 15   // must be >= 1
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (WDOG < 1) ? 1 : $clog2(WDOG + 1);
  localparam logic [bPC-1:0]   RST_PC   = bPC'(RESET_VEC);
  localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             stall_err_q;

  logic [bPC-1:0]   seq_pc_c;
  logic [bPC-1:0]   pc_next_c;
  logic             flush_if_c;
  logic             flush_id_c;
  logic             run_stall_c;

  // Sequential fetch address; the top address wraps to zero by truncation.
  assign seq_pc_c = bus.pc_current + bPC'(1);

  // State, watchdog counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_q == WDOG_CNT) begin
        stall_err_q <= 1'b1;
      end
    end
  end

  // Next state, next PC, flush strobes and watchdog counter update.
  always_comb begin
    state_d     = state_q;
    pc_next_c   = RST_PC;
    flush_if_c  = 1'b0;
    flush_id_c  = 1'b0;
    run_stall_c = 1'b0;

    case (state_q)
      // One cycle presenting the reset vector; pc_current is not yet meaningful.
      BOOT: begin
        pc_next_c = RST_PC;
        state_d   = RUN;
      end

      // Fixed priority: branch, jump, halt, stall, increment.
      RUN: begin
        if (bus.br_taken) begin
          pc_next_c  = bus.br_target;
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
        end else if (bus.jump) begin
          pc_next_c  = bus.jump_target;
          flush_if_c = 1'b1;
        end else if (bus.halt) begin
          pc_next_c  = bus.pc_current;
          flush_if_c = 1'b1;
          state_d    = HALT;
        end else if (bus.stall) begin
          pc_next_c   = bus.pc_current;
          run_stall_c = 1'b1;
        end else begin
          pc_next_c = seq_pc_c;
        end
      end

      // Frozen until an older branch redirects or an external resume arrives.
      HALT: begin
        if (bus.br_taken) begin
          pc_next_c  = bus.br_target;
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
          state_d    = RUN;
        end else if (bus.resume) begin
          pc_next_c = seq_pc_c;
          state_d   = RUN;
        end else begin
          pc_next_c = bus.pc_current;
        end
      end

      // Unused encoding recovers through BOOT.
      default: begin
        pc_next_c = RST_PC;
        state_d   = BOOT;
      end
    endcase

    // Count consecutive stalled RUN cycles, saturating at the watchdog limit.
    if (run_stall_c) begin
      stall_cnt_d = (stall_cnt_q == WDOG_CNT) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = '0;
    end
  end

  // Outputs: next PC and flushes are combinational; state and error come from registers.
  assign bus.pc_next     = pc_next_c;
  assign bus.flush_if    = flush_if_c;
  assign bus.flush_id    = flush_id_c;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.state       = state_q;
  assign bus.stall_err   = stall_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected outputs are queued as stimulus is
// driven and popped for comparison once the combinational outputs settle.
module tb_pc_sequencer;

  localparam logic [6:0] RV     = 7'h10;
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  typedef struct packed {
    logic [6:0] pc;
    logic       fi;
    logic       fd;
    logic       fv;
    logic [1:0] st;
  } obs_t;

  typedef struct packed {
    logic [6:0] pcc;
    logic       stl;
    logic       br;
    logic [6:0] brt;
    logic       j;
    logic [6:0] jt;
    logic       h;
    logic       r;
  } stim_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  obs_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  pc_sequencer_if #(.bPC(7)) bus ();

  pc_sequencer #(.bPC(7), .RESET_VEC(16), .WDOG(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic obs_t observe();
    obs_t x;
    x.pc = bus.pc_next;
    x.fi = bus.flush_if;
    x.fd = bus.flush_id;
    x.fv = bus.fetch_valid;
    x.st = bus.state;
    return x;
  endfunction

  function automatic obs_t mk(logic [6:0] pc, logic fi, logic fd, logic [1:0] st);
    obs_t x;
    x.pc = pc;
    x.fi = fi;
    x.fd = fd;
    x.fv = (st == S_RUN);
    x.st = st;
    return x;
  endfunction

  function automatic stim_t mk_stim(logic [6:0] pcc, logic stl, logic br, logic [6:0] brt,
                                    logic j, logic [6:0] jt, logic h, logic r);
    stim_t s;
    s.pcc = pcc; s.stl = stl; s.br = br; s.brt = brt;
    s.j = j; s.jt = jt; s.h = h; s.r = r;
    return s;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("pc_next=%h flush_if=%b flush_id=%b fetch_valid=%b state=%0d",
                     x.pc, x.fi, x.fd, x.fv, x.st);
  endfunction

  task automatic drive(input stim_t s, input obs_t e);
    bus.pc_current  = s.pcc;
    bus.stall       = s.stl;
    bus.br_taken    = s.br;
    bus.br_target   = s.brt;
    bus.jump        = s.j;
    bus.jump_target = s.jt;
    bus.halt        = s.h;
    bus.resume      = s.r;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset hold, BOOT cycle ignoring every input, then sequential fetch from the vector.
  task automatic test_reset();
    obs_t e, o;
    #1 reset = 1'b1;
    drive(mk_stim(7'h55, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0), mk(RV, 1'b0, 1'b0, S_BOOT));
    #1;
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %s, want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (bus.stall_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.stall_err); end
    tick();
    reset = 1'b0;
    drive(mk_stim(7'h55, 1'b1, 1'b1, 7'h22, 1'b1, 7'h33, 1'b1, 1'b1), mk(RV, 1'b0, 1'b0, S_BOOT));
    #1;
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL boot: got %s, want %s", fmt(o), fmt(e)); end
    tick();
    for (int i = 0; i < 6; i++) begin
      logic [6:0] pc;
      pc = RV + 7'(i);
      drive(mk_stim(pc, 1'b0, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0), mk(pc + 7'd1, 1'b0, 1'b0, S_RUN));
      #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL run_seq[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      tick();
    end
  endtask

  // Increment across the top of the address space.
  task automatic test_wrap();
    obs_t e, o;
    stim_t s [3];
    obs_t  x [3];
    s = '{mk_stim(7'h7E, 0, 0, 0, 0, 0, 0, 0), mk_stim(7'h7F, 0, 0, 0, 0, 0, 0, 0),
          mk_stim(7'h00, 0, 0, 0, 0, 0, 0, 0)};
    x = '{mk(7'h7F, 0, 0, S_RUN), mk(7'h00, 0, 0, S_RUN), mk(7'h01, 0, 0, S_RUN)};
    for (int i = 0; i < 3; i++) begin
      drive(s[i], x[i]);
      #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      tick();
    end
  endtask

  // Branch > jump > halt > stall > increment, including halt squashed by a branch.
  task automatic test_priority();
    obs_t e, o;
    stim_t s [5];
    obs_t  x [5];
    s = '{mk_stim(7'h33, 1, 1, 7'h20, 1, 7'h30, 1, 0),
          mk_stim(7'h20, 1, 0, 7'h00, 1, 7'h30, 1, 0),
          mk_stim(7'h30, 1, 0, 7'h00, 0, 7'h00, 0, 0),
          mk_stim(7'h30, 1, 1, 7'h44, 0, 7'h00, 0, 0),
          mk_stim(7'h44, 0, 0, 7'h00, 0, 7'h00, 0, 1)};
    x = '{mk(7'h20, 1, 1, S_RUN), mk(7'h30, 1, 0, S_RUN), mk(7'h30, 0, 0, S_RUN),
          mk(7'h44, 1, 1, S_RUN), mk(7'h45, 0, 0, S_RUN)};
    for (int i = 0; i < 5; i++) begin
      drive(s[i], x[i]);
      #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL priority[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      tick();
    end
  endtask

  // Halt freezes the PC; resume continues sequentially; a branch in HALT redirects.
  task automatic test_halt();
    obs_t e, o;
    stim_t s [17];
    obs_t  x [17];
    s[0] = mk_stim(7'h05, 0, 0, 7'h00, 0, 7'h00, 1, 0);
    x[0] = mk(7'h05, 1, 0, S_RUN);
    for (int i = 1; i <= 10; i++) begin
      s[i] = mk_stim(7'h05, 1'(i), 0, 7'h00, 1'(i >> 1), 7'h3A, 1'(i >> 2), 0);
      x[i] = mk(7'h05, 0, 0, S_HALT);
    end
    s[11] = mk_stim(7'h05, 0, 0, 7'h00, 1, 7'h3A, 0, 1);
    x[11] = mk(7'h06, 0, 0, S_HALT);
    s[12] = mk_stim(7'h06, 0, 0, 7'h00, 0, 7'h00, 0, 0);
    x[12] = mk(7'h07, 0, 0, S_RUN);
    s[13] = mk_stim(7'h07, 1, 0, 7'h00, 0, 7'h00, 1, 0);
    x[13] = mk(7'h07, 1, 0, S_RUN);
    s[14] = mk_stim(7'h07, 0, 0, 7'h00, 0, 7'h00, 0, 0);
    x[14] = mk(7'h07, 0, 0, S_HALT);
    s[15] = mk_stim(7'h07, 0, 1, 7'h40, 0, 7'h00, 0, 1);
    x[15] = mk(7'h40, 1, 1, S_HALT);
    s[16] = mk_stim(7'h40, 0, 0, 7'h00, 0, 7'h00, 0, 0);
    x[16] = mk(7'h41, 0, 0, S_RUN);
    for (int i = 0; i < 17; i++) begin
      drive(s[i], x[i]);
      #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL halt[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      tick();
    end
  endtask

  // WDOG=3: interrupted stalls never trip; three in a row trip one cycle late and stick.
  task automatic test_watchdog();
    obs_t e, o;
    stim_t s [16];
    obs_t  x [16];
    logic  ex_err [16];
    stim_t st_s, fr_s;
    obs_t  st_x, fr_x;
    st_s = mk_stim(7'h50, 1, 0, 7'h00, 0, 7'h00, 0, 0);
    fr_s = mk_stim(7'h50, 0, 0, 7'h00, 0, 7'h00, 0, 0);
    st_x = mk(7'h50, 0, 0, S_RUN);
    fr_x = mk(7'h51, 0, 0, S_RUN);
    s = '{st_s, st_s, fr_s, st_s, st_s, fr_s, fr_s,
          st_s, st_s, st_s, fr_s, fr_s,
          mk_stim(7'h50, 0, 0, 7'h00, 0, 7'h00, 1, 0), st_s,
          mk_stim(7'h50, 0, 0, 7'h00, 0, 7'h00, 0, 1), fr_s};
    x = '{st_x, st_x, fr_x, st_x, st_x, fr_x, fr_x,
          st_x, st_x, st_x, fr_x, fr_x,
          mk(7'h50, 1, 0, S_RUN), mk(7'h50, 0, 0, S_HALT),
          mk(7'h51, 0, 0, S_HALT), fr_x};
    ex_err = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 16; i++) begin
      drive(s[i], x[i]);
      #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wdog[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      n_cmp++;
      if (bus.stall_err !== ex_err[i]) begin
        n_fail++;
        $display("FAIL wdog_err[%0d]: got %b want %b", i, bus.stall_err, ex_err[i]);
      end
      tick();
    end
  endtask

  // Async reset mid-cycle clears the sticky error at once and restarts through BOOT.
  task automatic test_reset_midrun();
    obs_t e, o;
    #2 reset = 1'b1;
    drive(mk_stim(7'h50, 1, 0, 7'h00, 0, 7'h00, 0, 0), mk(RV, 0, 0, S_BOOT));
    #1;
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL midrst_hold: got %s, want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (bus.stall_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", bus.stall_err); end
    tick();
    reset = 1'b0;
    drive(mk_stim(7'h66, 0, 0, 7'h00, 0, 7'h00, 0, 0), mk(RV, 0, 0, S_BOOT));
    #1;
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL midrst_boot: got %s, want %s", fmt(o), fmt(e)); end
    tick();
    drive(mk_stim(RV, 0, 0, 7'h00, 0, 7'h00, 0, 0), mk(RV + 7'd1, 0, 0, S_RUN));
    #1;
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL midrst_run: got %s, want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (bus.stall_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err_run: got %b want 0", bus.stall_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_halt();
    test_watchdog();
    test_reset_midrun();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the pipelined MIPS fetch stage. It computes the value loaded into the program counter register each clock from sequential increment, EX-stage branch redirect, ID-stage jump redirect, hazard stall and halt/resume requests. It also generates IF/ID flush strobes and a stall watchdog error. It sits between the hazard/branch logic and the PC register: `pc_next` drives the PC input, and the PC output returns as `pc_current`.

## Interface
- `bPC`, 7: PC width in bits (word address).
- `RESET_VEC`, 0: fetch address after reset.
- `WDOG`, 15: number of consecutive stall cycles that sets `stall_err`; must be ≥1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-high.
- `pc_current` in bPC: present PC register value.
- `stall` in 1: load-use hazard; hold PC.
- `br_taken` in 1: EX-stage branch resolved taken.
- `br_target` in bPC: branch target address.
- `jump` in 1: ID-stage jump decoded.
- `jump_target` in bPC: jump target address.
- `halt` in 1: ID-stage halt instruction decoded.
- `resume` in 1: external restart request while halted.
- `pc_next` out bPC: combinational next PC value.
- `flush_if` out 1: combinational; squash the IF/ID instruction.
- `flush_id` out 1: combinational; squash the ID/EX instruction.
- `fetch_valid` out 1: combinational, `state==RUN`.
- `state` out 2: BOOT=0, RUN=1, HALT=2; value 3 is unused.
- `stall_err` out 1: registered, sticky watchdog flag.

## Operation
- The FSM state register, `stall_cnt` (width ⌈log2(WDOG+1)⌉) and `stall_err` are the only registers.
- Async reset: `state`=BOOT, `stall_cnt`=0, `stall_err`=0.
- While reset is held: `pc_next`=RESET_VEC, flushes=0, `fetch_valid`=0.
- Increment rule: seq = (`pc_current`+1) mod 2^bPC. The value 2^bPC−1 wraps to 0.

BOOT:
- `pc_next`=RESET_VEC, both flushes=0.
- Next state is RUN unconditionally. All other inputs are ignored.

RUN, fixed priority (first match wins):
1. `br_taken`: `pc_next`=`br_target`, `flush_if`=1, `flush_id`=1.
2. `jump`: `pc_next`=`jump_target`, `flush_if`=1.
3. `halt`: `pc_next`=`pc_current`, `flush_if`=1, next state HALT.
4. `stall`: `pc_next`=`pc_current`, no flush.
5. Otherwise: `pc_next`=seq.
- `stall` does not block a redirect: a branch or jump overrides `stall`. A halt is suppressed when `br_taken` is also asserted, because the halt lies on a squashed path.
- Unlisted flushes are 0.

HALT:
- If `br_taken`: `pc_next`=`br_target`, both flushes=1, next state RUN. This is an older instruction redirecting, so the halt is discarded.
- Else if `resume`: `pc_next`=seq, next state RUN.
- Otherwise `pc_next`=`pc_current`.
- `jump`, `halt` and `stall` are ignored.

Watchdog:
- In RUN, a cycle where rule 4 applies increments `stall_cnt`, saturating at WDOG.
- Any other cycle, and any cycle not in RUN, clears `stall_cnt`.
- When `stall_cnt` reaches WDOG, `stall_err` is set on the following edge. It stays set until reset.

## Timing
- `pc_next` and the flushes are combinational from inputs and state, with zero latency. The PC register captures `pc_next` on the same rising edge.
- Redirect penalty:
  - Branch: 2 bubbles (IF/ID and ID/EX flushed).
  - Jump: 1 bubble.
  - Halt: 1 squashed fetch, then PC frozen.
- First fetch: `pc_current`=RESET_VEC one edge after BOOT is entered. RUN starts on the next edge.
- Reset deassertion mid-operation:
  - The state machine always restarts in BOOT.
  - `pc_current` is not sampled in BOOT.
- Watchdog detection: WDOG consecutive stalled RUN cycles set `stall_err` at the end of cycle WDOG+1.

## Test plan
- Reset with bPC=7, RESET_VEC=0x10, then release -> BOOT for 1 cycle, `pc_next`=0x10. Then RUN, with `pc_next` = 0x11, 0x12, … for unstalled cycles.
- Wrap: `pc_current`=0x7F in RUN with no requests -> `pc_next`=0x00.
- Priority: `br_taken`=1, `br_target`=0x20, `jump`=1, `jump_target`=0x30, `halt`=1, `stall`=1 in the same cycle -> `pc_next`=0x20, both flushes=1, state stays RUN.
- Halt at `pc_current`=0x05 -> `flush_if`=1 and state HALT. PC then holds 0x05 for 10 cycles with `jump`/`stall` toggling. `resume` -> `pc_next`=0x06, state RUN. Repeat, but assert `br_taken`=1, `br_target`=0x40 in HALT instead -> `pc_next`=0x40, both flushes=1, state RUN.
- Watchdog with WDOG=3:
  - 3 stalled RUN cycles -> `stall_err`=1 after the next edge.
  - 2 stalls, 1 free cycle, 2 stalls -> `stall_err` stays 0.
  - Once set, `stall_err` stays 1 until async reset, and clears immediately when reset asserts.
